// File: rtl/ucca_cfg_loader.sv
// Boot-time loader for the UCCA region bounds: reads the region table from META,
// validates every descriptor, then commits all bounds at once and locks them until reset.
module ucca_cfg_loader #(
   parameter logic [15:0] META_BASE   = 16'h0140,
   parameter logic [15:0] META_SIZE   = 16'h002A,
   parameter int unsigned NUM_REGIONS = 3,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   output logic                   mem_req_o,
   output logic [15:0]            mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [15:0]            mem_rdata_i,
   output logic [15:0]            ucc_min_0_o,
   output logic [15:0]            ucc_min_1_o,
   output logic [15:0]            ucc_min_2_o,
   output logic [15:0]            ucc_max_0_o,
   output logic [15:0]            ucc_max_1_o,
   output logic [15:0]            ucc_max_2_o,
   output logic [NUM_REGIONS-1:0] region_en_o,
   output logic                   cfg_done_o,
   output logic                   cfg_fault_o
);

   localparam int unsigned NumSlots = (NUM_REGIONS > 3) ? NUM_REGIONS : 3;
   localparam int unsigned IdxW     = $clog2(NumSlots);
   localparam logic [15:0] MetaEnd  = META_BASE + META_SIZE;
   localparam logic [3:0]  MaxCount = 4'(NUM_REGIONS);
   localparam logic [15:0] WaitLast = 16'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StRdCnt, StRdMin, StRdMax, StCheck, StCommit, StDone, StFault
   } state_e;

   state_e                 state_q;
   logic                   req_q;
   logic [15:0]            addr_q;
   logic [15:0]            wait_q;
   logic [3:0]             cnt_q;
   logic [3:0]             idx_q;
   logic [15:0]            shadow_min_q [NumSlots];
   logic [15:0]            shadow_max_q [NumSlots];
   logic [15:0]            ucc_min_q    [NumSlots];
   logic [15:0]            ucc_max_q    [NumSlots];
   logic [NUM_REGIONS-1:0] en_q;
   logic                   done_q;
   logic                   fault_q;

   logic            ack;
   logic            timeout;
   logic [IdxW-1:0] slot;
   logic [15:0]     chk_min;
   logic [15:0]     chk_max;
   logic            region_bad;

   // An ack is only meaningful while our request is up; ack wins over an expiring timeout.
   assign ack        = req_q & mem_ack_i;
   assign timeout    = req_q & ~mem_ack_i & (wait_q == WaitLast);
   assign slot       = idx_q[IdxW-1:0];
   assign chk_min    = shadow_min_q[slot];
   assign chk_max    = shadow_max_q[slot];
   assign region_bad = (chk_min > chk_max) | chk_min[0] | chk_max[0] |
                       ((chk_min <= MetaEnd) & (chk_max >= META_BASE));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         addr_q  <= META_BASE;
         wait_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         en_q    <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         for (int i = 0; i < NumSlots; i++) begin
            shadow_min_q[i] <= '0;
            shadow_max_q[i] <= '0;
            ucc_min_q[i]    <= 16'hFFFF;
            ucc_max_q[i]    <= 16'h0000;
         end
      end else begin
         case (state_q)
            StIdle: state_q <= StRdCnt;
            StRdCnt, StRdMin, StRdMax: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  wait_q <= '0;
               end else if (ack) begin
                  req_q  <= 1'b0;
                  addr_q <= addr_q + 16'd2;
                  if (state_q == StRdCnt) begin
                     cnt_q <= mem_rdata_i[3:0];
                     idx_q <= '0;
                     if ((mem_rdata_i[15:4] != 12'd0) || (mem_rdata_i[3:0] > MaxCount)) begin
                        state_q <= StFault;
                     end else if (mem_rdata_i[3:0] == 4'd0) begin
                        state_q <= StCommit;
                     end else begin
                        state_q <= StRdMin;
                     end
                  end else if (state_q == StRdMin) begin
                     shadow_min_q[slot] <= mem_rdata_i;
                     state_q            <= StRdMax;
                  end else begin
                     shadow_max_q[slot] <= mem_rdata_i;
                     if (idx_q == cnt_q - 4'd1) begin
                        idx_q   <= '0;
                        state_q <= StCheck;
                     end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= StRdMin;
                     end
                  end
               end else if (timeout) begin
                  req_q   <= 1'b0;
                  state_q <= StFault;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end
            StCheck: begin
               if (region_bad) begin
                  state_q <= StFault;
               end else if (idx_q == cnt_q - 4'd1) begin
                  state_q <= StCommit;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            StCommit: begin
               for (int i = 0; i < NUM_REGIONS; i++) begin
                  if (4'(i) < cnt_q) begin
                     ucc_min_q[i] <= shadow_min_q[i];
                     ucc_max_q[i] <= shadow_max_q[i];
                     en_q[i]      <= 1'b1;
                  end
               end
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: ;
            StFault: begin
               req_q   <= 1'b0;
               en_q    <= '0;
               done_q  <= 1'b1;
               fault_q <= 1'b1;
               for (int i = 0; i < NumSlots; i++) begin
                  ucc_min_q[i] <= 16'hFFFF;
                  ucc_max_q[i] <= 16'h0000;
               end
            end
            default: state_q <= StFault;
         endcase
      end
   end

   assign mem_req_o   = req_q;
   assign mem_addr_o  = addr_q;
   assign ucc_min_0_o = ucc_min_q[0];
   assign ucc_min_1_o = ucc_min_q[1];
   assign ucc_min_2_o = ucc_min_q[2];
   assign ucc_max_0_o = ucc_max_q[0];
   assign ucc_max_1_o = ucc_max_q[1];
   assign ucc_max_2_o = ucc_max_q[2];
   assign region_en_o = en_q;
   assign cfg_done_o  = done_q;
   assign cfg_fault_o = fault_q;

endmodule

// File: tb/tb_ucca_cfg_loader.sv
// Randomised bench for ucca_cfg_loader: a memory responder serves the META table and a
// table-level reference model predicts the committed outputs and the read sequence.
module tb_ucca_cfg_loader;

   localparam logic [15:0]  Base     = 16'h0140;
   localparam logic [15:0]  MetaEnd  = 16'h016A;
   localparam logic [100:0] RstVal   = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                                        16'hFFFF, 16'h0000, 3'b000, 1'b0, 1'b0};
   localparam logic [100:0] FaultVal = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                                        16'hFFFF, 16'h0000, 3'b000, 1'b1, 1'b1};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ucc_min_0, ucc_min_1, ucc_min_2;
   logic [15:0] ucc_max_0, ucc_max_1, ucc_max_2;
   logic [2:0]  region_en;
   logic        cfg_done;
   logic        cfg_fault;

   always #5 clk = ~clk;

   ucca_cfg_loader dut (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .ucc_min_0_o (ucc_min_0),
      .ucc_min_1_o (ucc_min_1),
      .ucc_min_2_o (ucc_min_2),
      .ucc_max_0_o (ucc_max_0),
      .ucc_max_1_o (ucc_max_1),
      .ucc_max_2_o (ucc_max_2),
      .region_en_o (region_en),
      .cfg_done_o  (cfg_done),
      .cfg_fault_o (cfg_fault)
   );

   logic [15:0] mem [16];
   logic [15:0] addr_log [$];
   int          max_delay  = 1;
   int          hold_idx   = -1;
   int          hold_delay = 0;
   bit          noise      = 1'b0;
   int          hold_viol  = 0;
   int          early_viol = 0;
   int          checks     = 0;
   int          failures   = 0;

   bit           rsp_busy = 1'b0;
   int           rsp_left = 0;
   logic [15:0]  rsp_cur;
   logic [100:0] rsp_obs;

   function automatic logic [100:0] obs();
      return {ucc_min_0, ucc_max_0, ucc_min_1, ucc_max_1, ucc_min_2, ucc_max_2,
              region_en, cfg_done, cfg_fault};
   endfunction

   function automatic logic [15:0] mem_word(input logic [15:0] addr);
      logic [15:0] off;
      off = addr - Base;
      if (off < 16'd32) return mem[off[4:1]];
      return 16'hBAD0;
   endfunction

   function automatic bit addr_seq_ok(input int reads);
      if (addr_log.size() != reads) return 1'b0;
      for (int k = 0; k < reads; k++) begin
         if (addr_log[k] !== Base + 16'(2 * k)) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Memory responder: acks each request after a chosen delay, optionally injecting stray acks.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         rsp_obs = obs();
         if (!cfg_done && rsp_obs !== RstVal) early_viol++;
         if (mem_req) begin
            if (!rsp_busy) begin
               rsp_busy = 1'b1;
               rsp_cur  = mem_addr;
               addr_log.push_back(mem_addr);
               rsp_left = (addr_log.size() - 1 == hold_idx) ? hold_delay
                                                             : $urandom_range(max_delay, 0);
            end else if (mem_addr !== rsp_cur) begin
               hold_viol++;
            end
            if (rsp_left == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(mem_addr);
               rsp_busy  = 1'b0;
            end else begin
               rsp_left--;
            end
         end else begin
            rsp_busy = 1'b0;
            if (noise && $urandom_range(3, 0) == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = 16'($urandom);
            end
         end
      end
   end

   // Reference: interpret the table as a whole and predict outputs and number of reads.
   task automatic model(output logic [100:0] exp, output int reads);
      logic [15:0] mn [3];
      logic [15:0] mx [3];
      logic [2:0]  en;
      logic [15:0] lo, hi;
      bit          bad;
      int          cnt;
      for (int r = 0; r < 3; r++) begin
         mn[r] = 16'hFFFF;
         mx[r] = 16'h0000;
      end
      en  = 3'b000;
      bad = 1'b0;
      cnt = int'(mem[0]);
      if (cnt > 3) begin
         bad   = 1'b1;
         reads = 1;
      end else begin
         reads = 1 + 2 * cnt;
         for (int r = 0; r < cnt; r++) begin
            lo = mem[1 + 2 * r];
            hi = mem[2 + 2 * r];
            if (lo > hi || lo[0] || hi[0] || (lo <= MetaEnd && hi >= Base)) bad = 1'b1;
            mn[r] = lo;
            mx[r] = hi;
            en[r] = 1'b1;
         end
      end
      if (bad) exp = FaultVal;
      else     exp = {mn[0], mx[0], mn[1], mx[1], mn[2], mx[2], en, 1'b1, 1'b0};
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      addr_log.delete();
      hold_viol  = 0;
      early_viol = 0;
      reset_n    = 1'b1;
   endtask

   task automatic wait_done(output bit ok);
      for (int i = 0; i < 2000 && !cfg_done; i++) @(negedge clk);
      ok = cfg_done;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
   endtask

   task automatic test_reset();
      fill_random();
      mem[0] = 16'h0000;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({obs(), mem_req, mem_addr} !== {RstVal, 1'b0, Base}) begin
         failures++;
         $display("FAIL reset_values: got %h/%b/%h expected %h/0/%h",
                  obs(), mem_req, mem_addr, RstVal, Base);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({obs(), mem_req} !== {RstVal, 1'b0}) begin
         failures++;
         $display("FAIL idle_cycle: got %h/%b expected %h/0", obs(), mem_req, RstVal);
      end
   endtask

   task automatic test_count_zero();
      bit ok;
      fill_random();
      mem[0] = 16'h0000;
      do_reset();
      wait_done(ok);
      checks++;
      if (!ok || obs() !== {RstVal[100:5], 3'b000, 1'b1, 1'b0} || !addr_seq_ok(1)) begin
         failures++;
         $display("FAIL count_zero: got %h reads=%0d expected done, no regions, 1 read",
                  obs(), addr_log.size());
      end
   endtask

   task automatic test_directed_load();
      bit ok;
      fill_random();
      mem[0] = 16'd2;
      mem[1] = 16'hE000; mem[2] = 16'hE0FE;
      mem[3] = 16'hE100; mem[4] = 16'hE1FE;
      max_delay = 1;
      do_reset();
      wait_done(ok);
      checks++;
      if (!ok || obs() !== {16'hE000, 16'hE0FE, 16'hE100, 16'hE1FE, 16'hFFFF, 16'h0000,
                            3'b011, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL directed_outputs: got %h done=%b", obs(), ok);
      end
      checks++;
      if (!addr_seq_ok(5)) begin
         failures++;
         $display("FAIL directed_addrs: got %0d reads first=%h expected 5 reads from 0140",
                  addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 16'hXXXX);
      end
      checks++;
      if (hold_viol != 0 || early_viol != 0) begin
         failures++;
         $display("FAIL directed_protocol: got hold=%0d early=%0d expected 0/0",
                  hold_viol, early_viol);
      end
   endtask

   task automatic test_descriptor_faults();
      logic [15:0] tbl [5][3] = '{'{16'h0001, 16'hE200, 16'hE100},
                                  '{16'h0001, 16'h0100, 16'h0150},
                                  '{16'h0001, 16'hE001, 16'hE0FE},
                                  '{16'h0004, 16'hE000, 16'hE0FE},
                                  '{16'h0012, 16'hE000, 16'hE0FE}};
      int          exp_reads [5] = '{3, 3, 3, 1, 1};
      bit          ok;
      for (int c = 0; c < 5; c++) begin
         fill_random();
         for (int k = 0; k < 3; k++) mem[k] = tbl[c][k];
         do_reset();
         wait_done(ok);
         repeat (2) @(negedge clk);
         checks++;
         if (!ok || obs() !== FaultVal || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fault_case%0d: got %h req=%b expected %h req=0",
                     c, obs(), mem_req, FaultVal);
         end
         checks++;
         if (!addr_seq_ok(exp_reads[c])) begin
            failures++;
            $display("FAIL fault_case%0d_reads: got %0d expected %0d",
                     c, addr_log.size(), exp_reads[c]);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      fill_random();
      mem[0] = 16'd2;
      mem[1] = 16'hE000; mem[2] = 16'hE0FE;
      mem[3] = 16'hE100; mem[4] = 16'hE1FE;
      max_delay  = 2;
      hold_idx   = 2;
      hold_delay = 16;
      do_reset();
      wait_done(ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || obs() !== FaultVal || !addr_seq_ok(3)) begin
         failures++;
         $display("FAIL timeout_16: got %h reads=%0d expected %h reads=3",
                  obs(), addr_log.size(), FaultVal);
      end
      hold_delay = 15;
      do_reset();
      wait_done(ok);
      checks++;
      if (!ok || obs() !== {16'hE000, 16'hE0FE, 16'hE100, 16'hE1FE, 16'hFFFF, 16'h0000,
                            3'b011, 1'b1, 1'b0} || !addr_seq_ok(5)) begin
         failures++;
         $display("FAIL ack_on_edge16: got %h reads=%0d expected success with 5 reads",
                  obs(), addr_log.size());
      end
      hold_idx = -1;
   endtask

   task automatic test_reset_mid_load();
      logic [100:0] exp;
      int           reads;
      bit           ok;
      fill_random();
      mem[0] = 16'd3;
      mem[1] = 16'h0010; mem[2] = 16'h0100;
      mem[3] = 16'h8000; mem[4] = 16'h80FE;
      mem[5] = 16'hF000; mem[6] = 16'hFFFE;
      model(exp, reads);
      max_delay = 5;
      for (int rep = 0; rep < 3; rep++) begin
         do_reset();
         for (int i = 0; i < 500 && addr_log.size() < 3; i++) @(negedge clk);
         checks++;
         if (addr_log.size() < 3) begin
            failures++;
            $display("FAIL midload_reach_rdmax: got %0d reads expected 3", addr_log.size());
         end
         reset_n = 1'b0;
         #1;
         checks++;
         if ({obs(), mem_req, mem_addr} !== {RstVal, 1'b0, Base}) begin
            failures++;
            $display("FAIL midload_abort: got %h/%b/%h expected %h/0/%h",
                     obs(), mem_req, mem_addr, RstVal, Base);
         end
         do_reset();
         wait_done(ok);
         checks++;
         if (!ok || obs() !== exp || !addr_seq_ok(reads) || early_viol != 0) begin
            failures++;
            $display("FAIL midload_reload: got %h reads=%0d early=%0d expected %h reads=%0d",
                     obs(), addr_log.size(), early_viol, exp, reads);
         end
      end
   endtask

   task automatic test_random();
      logic [100:0] exp;
      logic [100:0] snap;
      int           reads;
      int           cnt;
      int           kind;
      int           nlog;
      logic [15:0]  lo, hi;
      bit           ok;
      noise     = 1'b1;
      max_delay = 5;
      for (int it = 0; it < 30; it++) begin
         fill_random();
         cnt    = $urandom_range(4, 0);
         mem[0] = ($urandom_range(7, 0) == 0) ? 16'($urandom) : 16'(cnt);
         for (int r = 0; r < 4; r++) begin
            if ($urandom_range(1, 0) == 0) begin
               lo = 16'($urandom_range(32'h013C, 0)) & 16'hFFFE;
               hi = lo + (16'($urandom_range(2, 0)) & 16'hFFFE);
            end else begin
               lo = 16'($urandom_range(32'hFF00, 32'h0170)) & 16'hFFFE;
               hi = lo + (16'($urandom_range(254, 0)) & 16'hFFFE);
            end
            kind = $urandom_range(7, 0);
            if (kind == 0) begin
               {lo, hi} = {hi + 16'd2, lo};
            end else if (kind == 1) begin
               lo[0] = 1'b1;
            end else if (kind == 2) begin
               hi[0] = 1'b1;
            end else if (kind == 3) begin
               lo = 16'h0100 + (16'($urandom_range(64, 0)) << 1);
               hi = 16'h0160 + (16'($urandom_range(64, 0)) << 1);
            end
            mem[1 + 2 * r] = lo;
            mem[2 + 2 * r] = hi;
         end
         model(exp, reads);
         do_reset();
         wait_done(ok);
         checks++;
         if (!ok || obs() !== exp) begin
            failures++;
            $display("FAIL random%0d_outputs: got %h expected %h", it, obs(), exp);
         end
         checks++;
         if (!addr_seq_ok(reads) || hold_viol != 0 || early_viol != 0) begin
            failures++;
            $display("FAIL random%0d_protocol: got reads=%0d hold=%0d early=%0d expected %0d/0/0",
                     it, addr_log.size(), hold_viol, early_viol, reads);
         end
         snap = obs();
         nlog = addr_log.size();
         repeat (6) @(negedge clk);
         checks++;
         if (obs() !== snap || addr_log.size() != nlog || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL random%0d_frozen: got %h reads=%0d req=%b expected %h reads=%0d req=0",
                     it, obs(), addr_log.size(), mem_req, snap, nlog);
         end
      end
      noise = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_zero();
      test_directed_load();
      test_descriptor_faults();
      test_timeout();
      test_reset_mid_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
